// File: rtl/ram_burst_ctrl.sv
// Burst command front-end for a single-port synchronous RAM.
// Takes write/read bursts over valid/ready and drives registered RAM address, data and strobes.
module ram_burst_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic              ram_cs,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addrCnt_q, addrCnt_d;
    logic [LEN_W-1:0]  beatCnt_q, beatCnt_d;
    logic              cmdReady_q, cmdReady_d;
    logic              wrReady_q, wrReady_d;
    logic              rdValid_q, rdValid_d;
    logic              rdLast_q, rdLast_d;
    logic              lastInFlight_q, lastInFlight_d;
    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic [DATA_W-1:0] ramDin_q, ramDin_d;
    logic              ramWr_q, ramWr_d;
    logic              ramRd_q, ramRd_d;

    logic cmdHs, wrHs, rdHs, rdIssue;

    assign cmdHs = cmd_valid & cmdReady_q;
    assign wrHs  = wr_valid & wrReady_q;
    assign rdHs  = rdValid_q & rd_ready;
    // A read is launched only when nothing is in flight and the output slot frees up this edge.
    assign rdIssue = (state_q == READ) & ~ramRd_q & (~rdValid_q | rd_ready);

    always_comb begin
        state_d        = state_q;
        addrCnt_d      = addrCnt_q;
        beatCnt_d      = beatCnt_q;
        cmdReady_d     = cmdReady_q;
        wrReady_d      = wrReady_q;
        rdValid_d      = rdValid_q;
        rdLast_d       = rdLast_q;
        lastInFlight_d = lastInFlight_q;
        ramAddr_d      = ramAddr_q;
        ramDin_d       = ramDin_q;
        ramWr_d        = 1'b0;
        ramRd_d        = 1'b0;

        if (rdHs) begin
            rdValid_d = 1'b0;
            rdLast_d  = 1'b0;
        end
        // The RAM output updates on the edge after ram_rd, so the beat becomes valid then.
        if (ramRd_q) begin
            rdValid_d = 1'b1;
            rdLast_d  = lastInFlight_q;
        end

        case (state_q)
            IDLE: begin
                cmdReady_d = 1'b1;
                if (cmdHs) begin
                    cmdReady_d = 1'b0;
                    addrCnt_d  = cmd_addr;
                    beatCnt_d  = cmd_len;
                    if (cmd_write) begin
                        state_d   = WRITE;
                        wrReady_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (wrHs) begin
                    ramWr_d   = 1'b1;
                    ramAddr_d = addrCnt_q;
                    ramDin_d  = wr_data;
                    addrCnt_d = addrCnt_q + 1'b1;
                    beatCnt_d = beatCnt_q - 1'b1;
                    if (beatCnt_q == '0) begin
                        state_d    = IDLE;
                        wrReady_d  = 1'b0;
                        cmdReady_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (rdIssue) begin
                    ramRd_d        = 1'b1;
                    ramAddr_d      = addrCnt_q;
                    addrCnt_d      = addrCnt_q + 1'b1;
                    beatCnt_d      = beatCnt_q - 1'b1;
                    lastInFlight_d = (beatCnt_q == '0);
                    if (beatCnt_q == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rdHs && rdLast_q) begin
                    state_d    = IDLE;
                    cmdReady_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addrCnt_q      <= '0;
            beatCnt_q      <= '0;
            cmdReady_q     <= 1'b0;
            wrReady_q      <= 1'b0;
            rdValid_q      <= 1'b0;
            rdLast_q       <= 1'b0;
            lastInFlight_q <= 1'b0;
            ramAddr_q      <= '0;
            ramDin_q       <= '0;
            ramWr_q        <= 1'b0;
            ramRd_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            addrCnt_q      <= addrCnt_d;
            beatCnt_q      <= beatCnt_d;
            cmdReady_q     <= cmdReady_d;
            wrReady_q      <= wrReady_d;
            rdValid_q      <= rdValid_d;
            rdLast_q       <= rdLast_d;
            lastInFlight_q <= lastInFlight_d;
            ramAddr_q      <= ramAddr_d;
            ramDin_q       <= ramDin_d;
            ramWr_q        <= ramWr_d;
            ramRd_q        <= ramRd_d;
        end
    end

    assign cmd_ready   = cmdReady_q;
    assign wr_ready    = wrReady_q;
    assign rd_valid    = rdValid_q;
    assign rd_last     = rdLast_q;
    assign rd_data     = ram_data_out;
    assign ram_address = ramAddr_q;
    assign ram_data_in = ramDin_q;
    assign ram_wr      = ramWr_q;
    assign ram_rd      = ramRd_q;
    assign ram_cs      = ramWr_q | ramRd_q;

endmodule
